// File: rtl/draw_engine.sv
// rtl/draw_engine.sv - rectangle rasteriser for bricks, paddle and ball (optional DRAW_ENGINE_ALIVE_MASK_EN)
module draw_engine #(
  parameter int BRICK_X0      = 8,
  parameter int BRICK_PITCH_X = 38,
  parameter int BRICK_Y0      = 10,
  parameter int BRICK_PITCH_Y = 10,
  parameter int BRICK_W       = 32,
  parameter int BRICK_H       = 6,
  parameter int PADDLE_Y      = 112,
  parameter int PADDLE_W      = 24,
  parameter int PADDLE_H      = 3,
  parameter int BALL_SZ       = 2,
  parameter int PADDLE_X_RST  = 68,
  parameter int BALL_X_RST    = 79,
  parameter int BALL_Y_RST    = 60
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [4:0]  ld_draw,
  input  logic [7:0]  paddle_x,
  input  logic [7:0]  ball_x,
  input  logic [6:0]  ball_y,
  output logic        busy,
  output logic        plot,
  output logic [7:0]  x,
  output logic [6:0]  y,
`ifdef DRAW_ENGINE_ALIVE_MASK_EN
  output logic [11:0] brick_alive,
`endif
  output logic [2:0]  colour
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_PLOT, S_DONE} state_t;

  state_t      state_q, state_d;
  logic [4:0]  acc_code_q, acc_code_d;
  logic [8:0]  org_x_q, org_x_d;
  logic [8:0]  org_y_q, org_y_d;
  logic [7:0]  w_q, w_d;
  logic [7:0]  h_q, h_d;
  logic [2:0]  col_q, col_d;
  logic [7:0]  cx_q, cx_d;
  logic [7:0]  cy_q, cy_d;
  logic [7:0]  pad_x_q, pad_x_d;
  logic [7:0]  ball_x_q, ball_x_d;
  logic [6:0]  ball_y_q, ball_y_d;
`ifdef DRAW_ENGINE_ALIVE_MASK_EN
  logic [11:0] alive_q, alive_d;
  logic [15:0] alive_ext;
  logic [3:0]  ld_idx;
  logic        ld_dead_erase;
`endif

  logic        cmd_valid;
  logic        start;
  logic        is_brick_draw;
  logic        is_brick_erase;
  logic [3:0]  brick_idx;
  logic [1:0]  brick_col;
  logic [1:0]  brick_row;
  logic [8:0]  px;
  logic [8:0]  py;
  logic        in_plot;

  // Start detection, brick decode of the accepted code, and the visible pixel outputs
  always_comb begin
    cmd_valid      = (ld_draw >= 5'd1) && (ld_draw <= 5'd28);
    start          = (state_q == S_IDLE) && cmd_valid && (ld_draw != acc_code_q);
    busy           = (state_q != S_IDLE) || start;
    is_brick_draw  = (acc_code_q >= 5'd1) && (acc_code_q <= 5'd12);
    is_brick_erase = (acc_code_q >= 5'd17) && (acc_code_q <= 5'd28);
    // Codes 1..12 and 17..28 share their low nibble, so one subtract covers both
    brick_idx      = acc_code_q[3:0] - 4'd1;
    brick_col      = brick_idx[1:0];
    brick_row      = brick_idx[3:2];
    px             = org_x_q + {1'b0, cx_q};
    py             = org_y_q + {1'b0, cy_q};
    in_plot        = (state_q == S_PLOT);
    // Off-screen pixels still consume a cycle but never write the frame buffer
    plot           = in_plot && (px <= 9'd159) && (py <= 9'd119);
    x              = in_plot ? px[7:0] : 8'd0;
    y              = in_plot ? py[6:0] : 7'd0;
    colour         = in_plot ? col_q : 3'd0;
  end

`ifdef DRAW_ENGINE_ALIVE_MASK_EN
  // An erase aimed at a brick that is already gone skips the raster entirely
  always_comb begin
    alive_ext     = {4'b0000, alive_q};
    ld_idx        = ld_draw[3:0] - 4'd1;
    ld_dead_erase = (ld_draw >= 5'd17) && !alive_ext[ld_idx];
  end
  assign brick_alive = alive_q;
`endif

  // Next-state, rectangle setup, raster counters and stored-position updates
  always_comb begin
    state_d    = state_q;
    acc_code_d = acc_code_q;
    org_x_d    = org_x_q;
    org_y_d    = org_y_q;
    w_d        = w_q;
    h_d        = h_q;
    col_d      = col_q;
    cx_d       = cx_q;
    cy_d       = cy_q;
    pad_x_d    = pad_x_q;
    ball_x_d   = ball_x_q;
    ball_y_d   = ball_y_q;
`ifdef DRAW_ENGINE_ALIVE_MASK_EN
    alive_d    = alive_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          acc_code_d = ld_draw;
`ifdef DRAW_ENGINE_ALIVE_MASK_EN
          state_d    = ld_dead_erase ? S_DONE : S_LOAD;
`else
          state_d    = S_LOAD;
`endif
        end else if (ld_draw == 5'd0) begin
          acc_code_d = 5'd0;
        end
      end
      S_LOAD: begin
        cx_d = 8'd0;
        cy_d = 8'd0;
        if (is_brick_draw || is_brick_erase) begin
          org_x_d = 9'(BRICK_X0) + 9'(BRICK_PITCH_X) * {7'd0, brick_col};
          org_y_d = 9'(BRICK_Y0) + 9'(BRICK_PITCH_Y) * {7'd0, brick_row};
          w_d     = 8'(BRICK_W);
          h_d     = 8'(BRICK_H);
          if (is_brick_erase) begin
            col_d = 3'b000;
          end else begin
            case (brick_row)
              2'd0:    col_d = 3'b100;
              2'd1:    col_d = 3'b110;
              2'd2:    col_d = 3'b010;
              default: col_d = 3'b000;
            endcase
          end
        end else if (acc_code_q == 5'd13 || acc_code_q == 5'd14) begin
          org_x_d = (acc_code_q == 5'd14) ? {1'b0, paddle_x} : {1'b0, pad_x_q};
          org_y_d = 9'(PADDLE_Y);
          w_d     = 8'(PADDLE_W);
          h_d     = 8'(PADDLE_H);
          col_d   = (acc_code_q == 5'd14) ? 3'b111 : 3'b000;
        end else begin
          org_x_d = (acc_code_q == 5'd16) ? {1'b0, ball_x} : {1'b0, ball_x_q};
          org_y_d = (acc_code_q == 5'd16) ? {2'b00, ball_y} : {2'b00, ball_y_q};
          w_d     = 8'(BALL_SZ);
          h_d     = 8'(BALL_SZ);
          col_d   = (acc_code_q == 5'd16) ? 3'b111 : 3'b000;
        end
        state_d = S_PLOT;
      end
      S_PLOT: begin
        if (cx_q == w_q - 8'd1) begin
          cx_d = 8'd0;
          if (cy_q == h_q - 8'd1) begin
            state_d = S_DONE;
          end else begin
            cy_d = cy_q + 8'd1;
          end
        end else begin
          cx_d = cx_q + 8'd1;
        end
      end
      S_DONE: begin
        if (acc_code_q == 5'd14) begin
          pad_x_d = org_x_q[7:0];
        end
        if (acc_code_q == 5'd16) begin
          ball_x_d = org_x_q[7:0];
          ball_y_d = org_y_q[6:0];
        end
`ifdef DRAW_ENGINE_ALIVE_MASK_EN
        if (is_brick_draw)  alive_d[brick_idx] = 1'b1;
        if (is_brick_erase) alive_d[brick_idx] = 1'b0;
`endif
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= S_IDLE;
      acc_code_q <= 5'd0;
      org_x_q    <= 9'd0;
      org_y_q    <= 9'd0;
      w_q        <= 8'd0;
      h_q        <= 8'd0;
      col_q      <= 3'd0;
      cx_q       <= 8'd0;
      cy_q       <= 8'd0;
      pad_x_q    <= 8'(PADDLE_X_RST);
      ball_x_q   <= 8'(BALL_X_RST);
      ball_y_q   <= 7'(BALL_Y_RST);
`ifdef DRAW_ENGINE_ALIVE_MASK_EN
      alive_q    <= 12'hFFF;
`endif
    end else begin
      state_q    <= state_d;
      acc_code_q <= acc_code_d;
      org_x_q    <= org_x_d;
      org_y_q    <= org_y_d;
      w_q        <= w_d;
      h_q        <= h_d;
      col_q      <= col_d;
      cx_q       <= cx_d;
      cy_q       <= cy_d;
      pad_x_q    <= pad_x_d;
      ball_x_q   <= ball_x_d;
      ball_y_q   <= ball_y_d;
`ifdef DRAW_ENGINE_ALIVE_MASK_EN
      alive_q    <= alive_d;
`endif
    end
  end

endmodule

// File: tb/tb_draw_engine.sv
// tb/tb_draw_engine.sv - directed self-checking bench for draw_engine
module tb_draw_engine;

  logic        clk;
  logic        resetn;
  logic [4:0]  ld_draw;
  logic [7:0]  paddle_x;
  logic [7:0]  ball_x;
  logic [6:0]  ball_y;
  logic        busy;
  logic        plot;
  logic [7:0]  x;
  logic [6:0]  y;
  logic [2:0]  colour;
`ifdef DRAW_ENGINE_ALIVE_MASK_EN
  logic [11:0] brick_alive;
`endif

  int checks = 0;
  int errors = 0;

  draw_engine dut (
    .clk         (clk),
    .resetn      (resetn),
    .ld_draw     (ld_draw),
    .paddle_x    (paddle_x),
    .ball_x      (ball_x),
    .ball_y      (ball_y),
    .busy        (busy),
    .plot        (plot),
    .x           (x),
    .y           (y),
`ifdef DRAW_ENGINE_ALIVE_MASK_EN
    .brick_alive (brick_alive),
`endif
    .colour      (colour)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  // Runs until busy drops (or max_k cycles), recording plot statistics per negedge sample
  task automatic capture(input int max_k, output int np, output int fk, output int lk,
                         output int bk, output int fx, output int fy, output int fc,
                         output int lx, output int ly);
    np = 0; fk = -1; lk = -1; bk = -1; fx = -1; fy = -1; fc = -1; lx = -1; ly = -1;
    for (int k = 1; k <= max_k; k++) begin
      @(negedge clk);
      if (plot) begin
        np++;
        if (fk < 0) begin fk = k; fx = x; fy = y; fc = colour; end
        lk = k; lx = x; ly = y;
      end
      if (!busy) begin bk = k; break; end
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0; ld_draw = 5'd0; paddle_x = 8'd0; ball_x = 8'd0; ball_y = 7'd0;
    repeat (2) @(negedge clk);
    checks++; if (busy !== 1'b0)   begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (plot !== 1'b0)   begin errors++; $display("FAIL reset_plot: got %b expected 0", plot); end
    checks++; if (x !== 8'd0 || y !== 7'd0 || colour !== 3'd0) begin
      errors++; $display("FAIL reset_xyc: got %0d,%0d,%0d expected 0,0,0", x, y, colour); end
`ifdef DRAW_ENGINE_ALIVE_MASK_EN
    checks++; if (brick_alive !== 12'hFFF) begin errors++; $display("FAIL reset_alive: got %h expected fff", brick_alive); end
`endif
    resetn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_ignored();
    ld_draw = 5'd29;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checks++; if (busy !== 1'b0 || plot !== 1'b0) begin
        errors++; $display("FAIL ignored_cmd29: got busy=%b plot=%b expected 0 0", busy, plot); end
    end
    ld_draw = 5'd0;
    @(negedge clk);
  endtask

  task automatic test_brick1();
    int np, fk, lk, bk, fx, fy, fc, lx, ly;
    ld_draw = 5'd1;
    #1;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b1_busy_same_cycle: got %b expected 1", busy); end
    capture(400, np, fk, lk, bk, fx, fy, fc, lx, ly);
    checks++; if (fk != 2)   begin errors++; $display("FAIL b1_first_k: got %0d expected 2", fk); end
    checks++; if (fx != 8 || fy != 10) begin errors++; $display("FAIL b1_first_xy: got %0d,%0d expected 8,10", fx, fy); end
    checks++; if (fc != 4)   begin errors++; $display("FAIL b1_colour: got %0d expected 4", fc); end
    checks++; if (np != 192) begin errors++; $display("FAIL b1_nplots: got %0d expected 192", np); end
    checks++; if (lx != 39 || ly != 15) begin errors++; $display("FAIL b1_last_xy: got %0d,%0d expected 39,15", lx, ly); end
    checks++; if (lk != 193) begin errors++; $display("FAIL b1_last_k: got %0d expected 193", lk); end
    checks++; if (bk != 195) begin errors++; $display("FAIL b1_busy_low_k: got %0d expected 195", bk); end
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checks++; if (busy !== 1'b0 || plot !== 1'b0) begin
        errors++; $display("FAIL b1_held_no_restart: got busy=%b plot=%b expected 0 0", busy, plot); end
    end
  endtask

  task automatic test_brick7_repeat();
    int np, fk, lk, bk, fx, fy, fc, lx, ly;
    ld_draw = 5'd7;
    capture(400, np, fk, lk, bk, fx, fy, fc, lx, ly);
    checks++; if (fx != 84 || fy != 20) begin errors++; $display("FAIL b7_first_xy: got %0d,%0d expected 84,20", fx, fy); end
    checks++; if (fc != 6)   begin errors++; $display("FAIL b7_colour: got %0d expected 6", fc); end
    checks++; if (lx != 115 || ly != 25) begin errors++; $display("FAIL b7_last_xy: got %0d,%0d expected 115,25", lx, ly); end
    checks++; if (np != 192) begin errors++; $display("FAIL b7_nplots: got %0d expected 192", np); end
    ld_draw = 5'd0;
    @(negedge clk);
    ld_draw = 5'd7;
    capture(400, np, fk, lk, bk, fx, fy, fc, lx, ly);
    checks++; if (np != 192 || fx != 84) begin errors++; $display("FAIL b7_rerun: got np=%0d x=%0d expected 192 84", np, fx); end
    checks++; if (bk != 195) begin errors++; $display("FAIL b7_rerun_busy_low_k: got %0d expected 195", bk); end
  endtask

  task automatic test_paddle_clip();
    int np, fk, lk, bk, fx, fy, fc, lx, ly;
    ld_draw = 5'd0;
    @(negedge clk);
    paddle_x = 8'd150;
    ld_draw = 5'd14;
    capture(200, np, fk, lk, bk, fx, fy, fc, lx, ly);
    checks++; if (np != 30) begin errors++; $display("FAIL paddle_nplots: got %0d expected 30", np); end
    checks++; if (fx != 150 || fy != 112 || fc != 7) begin
      errors++; $display("FAIL paddle_first: got %0d,%0d,c%0d expected 150,112,c7", fx, fy, fc); end
    checks++; if (lx != 159 || ly != 114) begin errors++; $display("FAIL paddle_last_xy: got %0d,%0d expected 159,114", lx, ly); end
    checks++; if (bk != 75) begin errors++; $display("FAIL paddle_busy_low_k: got %0d expected 75", bk); end
    paddle_x = 8'd20;
    ld_draw = 5'd13;
    capture(200, np, fk, lk, bk, fx, fy, fc, lx, ly);
    checks++; if (fx != 150 || fy != 112 || fc != 0) begin
      errors++; $display("FAIL paddle_erase_first: got %0d,%0d,c%0d expected 150,112,c0", fx, fy, fc); end
    checks++; if (np != 30) begin errors++; $display("FAIL paddle_erase_nplots: got %0d expected 30", np); end
  endtask

  task automatic test_ball_change_mid();
    int np, busy_low_k;
    ball_x = 8'd40; ball_y = 7'd50;
    ld_draw = 5'd16;
    np = 0; busy_low_k = -1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (plot) np++;
      if (k == 2) begin
        checks++; if (plot !== 1'b1 || x !== 8'd40 || y !== 7'd50 || colour !== 3'd7) begin
          errors++; $display("FAIL ball_draw_first: got p%b %0d,%0d,c%0d expected p1 40,50,c7", plot, x, y, colour); end
        ld_draw = 5'd15;
        ball_x = 8'd99; ball_y = 7'd9;
      end
      if (k == 7) begin
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL ball_erase_start_busy: got %b expected 1", busy); end
      end
      if (k == 9) begin
        checks++; if (plot !== 1'b1 || x !== 8'd40 || y !== 7'd50 || colour !== 3'd0) begin
          errors++; $display("FAIL ball_erase_first: got p%b %0d,%0d,c%0d expected p1 40,50,c0", plot, x, y, colour); end
      end
      if (!busy && busy_low_k < 0) busy_low_k = k;
    end
    checks++; if (np != 8) begin errors++; $display("FAIL ball_nplots: got %0d expected 8", np); end
    checks++; if (busy_low_k != 14) begin errors++; $display("FAIL ball_busy_low_k: got %0d expected 14", busy_low_k); end
  endtask

  task automatic test_reset_mid_plot();
    int np, fk, lk, bk, fx, fy, fc, lx, ly;
    int seen;
    bit hit;
    ld_draw = 5'd12;
    seen = 0; hit = 0;
    for (int k = 1; k <= 300; k++) begin
      @(negedge clk);
      if (plot) seen++;
      if (seen == 50) begin hit = 1; break; end
    end
    checks++; if (!hit) begin errors++; $display("FAIL rst_mid_reach50: got %0d plots expected 50", seen); end
    resetn = 1'b0;
    ld_draw = 5'd0;
    #1;
    checks++; if (plot !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL rst_mid_async_drop: got plot=%b busy=%b expected 0 0", plot, busy); end
    checks++; if (x !== 8'd0 || y !== 7'd0) begin errors++; $display("FAIL rst_mid_xy: got %0d,%0d expected 0,0", x, y); end
    @(negedge clk);
    resetn = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checks++; if (plot !== 1'b0 || busy !== 1'b0) begin
        errors++; $display("FAIL rst_mid_stay_idle: got plot=%b busy=%b expected 0 0", plot, busy); end
    end
    ld_draw = 5'd13;
    capture(200, np, fk, lk, bk, fx, fy, fc, lx, ly);
    checks++; if (fx != 68 || fy != 112 || np != 72) begin
      errors++; $display("FAIL rst_paddle_stored: got %0d,%0d np=%0d expected 68,112 np=72", fx, fy, np); end
    ld_draw = 5'd15;
    capture(50, np, fk, lk, bk, fx, fy, fc, lx, ly);
    checks++; if (fx != 79 || fy != 60 || np != 4) begin
      errors++; $display("FAIL rst_ball_stored: got %0d,%0d np=%0d expected 79,60 np=4", fx, fy, np); end
  endtask

`ifdef DRAW_ENGINE_ALIVE_MASK_EN
  task automatic test_alive_mask();
    int np, fk, lk, bk, fx, fy, fc, lx, ly;
    ld_draw = 5'd0;
    @(negedge clk);
    ld_draw = 5'd18;
    capture(400, np, fk, lk, bk, fx, fy, fc, lx, ly);
    checks++; if (np != 192 || fx != 46 || fy != 10 || fc != 0) begin
      errors++; $display("FAIL alive_erase18: got np=%0d %0d,%0d,c%0d expected 192 46,10,c0", np, fx, fy, fc); end
    checks++; if (brick_alive !== 12'hFFD) begin errors++; $display("FAIL alive_mask_cleared: got %h expected ffd", brick_alive); end
    ld_draw = 5'd0;
    @(negedge clk);
    ld_draw = 5'd18;
    #1;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL alive_dead_busy0: got %b expected 1", busy); end
    capture(20, np, fk, lk, bk, fx, fy, fc, lx, ly);
    checks++; if (np != 0 || bk != 2) begin
      errors++; $display("FAIL alive_dead_skip: got np=%0d busy_low_k=%0d expected 0 2", np, bk); end
    ld_draw = 5'd2;
    capture(400, np, fk, lk, bk, fx, fy, fc, lx, ly);
    checks++; if (np != 192 || brick_alive !== 12'hFFF) begin
      errors++; $display("FAIL alive_redraw: got np=%0d mask=%h expected 192 fff", np, brick_alive); end
  endtask
`endif

  initial begin
    test_reset();
    test_ignored();
    test_brick1();
    test_brick7_repeat();
    test_paddle_clip();
    test_ball_change_mid();
    test_reset_mid_plot();
`ifdef DRAW_ENGINE_ALIVE_MASK_EN
    test_alive_mask();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
